// File: rtl/nanorv32_ahb_code_sram.sv
// -----------------------------------------------------------------------------
// nanorv32_ahb_code_sram
//   AHB-Lite slave in front of a word-organised code/data SRAM. It serves the
//   core's instruction-fetch port (and optionally its data port). Transfers are
//   address/data pipelined. Every OKAY data phase carries WAIT_STATES stall
//   cycles. Byte-lane strobes are applied on writes. Out-of-range, misaligned
//   or oversize transfers get a two-cycle ERROR response and never touch memory.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   hsel         slave select
//   haddr        byte address (address phase)
//   htrans       transfer type, bit 1 set = NONSEQ/SEQ
//   hsize        0=byte 1=half 2=word, larger values are illegal
//   hwrite       1 = write
//   hwdata       write data (data phase)
//   hready       bus-level ready (hreadyin)
//   hreadyout    slave ready
//   hresp        0=OKAY 1=ERROR
//   hrdata       read data, zero outside the final cycle of a read data phase
// -----------------------------------------------------------------------------
module nanorv32_ahb_code_sram #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // First byte address past the memory; 33 bits so the top of the map cannot wrap.
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + (33'(DEPTH) << 2);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t                state, state_nx;
  logic [2:0]            wait_cnt, wait_nx;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [3:0]            strb_q;
  logic                  write_q;

  logic [31:0]           mem [DEPTH];

  logic                  open;
  logic                  accept;
  logic                  legal;
  logic                  in_range;
  logic                  aligned;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            strb;
  logic                  last;

  // Final cycle of an OKAY data phase: data is returned / write data sampled.
  assign last = (state == DATA) && (wait_cnt == 3'd0);

  // The slave can take a new address phase when no data phase is stalling it.
  assign open   = (state == IDLE) || (state == ERR2) || last;
  assign accept = open && hsel && htrans[1] && hready;

  assign offset   = haddr - BASE_ADDR;
  assign word_idx = ADDR_WIDTH'(offset >> 2);
  assign in_range = (haddr >= BASE_ADDR) && ({1'b0, haddr} < LIMIT);

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    aligned = 1'b0;
    strb    = 4'b0000;
    unique case (hsize)
      3'd0: begin
        aligned = 1'b1;
        strb    = 4'b0001 << haddr[1:0];
      end
      3'd1: begin
        aligned = ~haddr[0];
        strb    = haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        aligned = (haddr[1:0] == 2'b00);
        strb    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign legal = in_range && aligned;

  // Next-state and response outputs.
  always_comb begin
    state_nx  = state;
    wait_nx   = wait_cnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state)
      DATA: begin
        if (wait_cnt != 3'd0) begin
          hreadyout = 1'b0;
          wait_nx   = wait_cnt - 3'd1;
        end
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nx  = ERR2;
      end
      ERR2:    hresp = 1'b1;
      default: ;
    endcase
    // IDLE, ERR2 and the last DATA cycle all follow the same accept rules.
    if (open) begin
      if (accept) begin
        state_nx = legal ? DATA : ERR1;
        wait_nx  = legal ? WS : 3'd0;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      word_q   <= '0;
      strb_q   <= 4'b0000;
      write_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (accept) begin
        word_q  <= word_idx;
        strb_q  <= strb;
        write_q <= hwrite;
      end
    end
  end

  // NOTE: the memory array has no reset; its contents are undefined after power-up and software must initialise it.
  // The commit is gated by state, which resets asynchronously, so a reset
  // during a data phase discards the pending write.
  always_ff @(posedge clk) begin
    if (last && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[word_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Full word is returned; the master picks the byte lanes it needs.
  assign hrdata = (last && !write_q) ? mem[word_q] : 32'h0000_0000;

endmodule

// File: tb/tb_nanorv32_ahb_code_sram.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_ahb_code_sram
//   Three instances (0, 2 and 3 wait states, different base addresses) driven
//   by a cycle-level AHB master. Expected responses come from a transaction
//   model: legality from address arithmetic, memory as an array of words, and
//   the response timeline from the wait-state count.
// -----------------------------------------------------------------------------
module tb_nanorv32_ahb_code_sram;

  localparam int NP    = 3;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int          WS_TAB   [NP] = '{0, 2, 3};
  localparam logic [31:0] BASE_TAB [NP] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000};

  typedef struct {
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gap;  // idle cycles before the address phase
    bit          cc;   // also compare read data against cv
    logic [31:0] cv;
  } tx_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NP-1:0]         hsel;
  logic [NP-1:0][31:0]   haddr;
  logic [NP-1:0][1:0]    htrans;
  logic [NP-1:0][2:0]    hsize;
  logic [NP-1:0]         hwrite;
  logic [NP-1:0][31:0]   hwdata;
  logic [NP-1:0]         hready;
  logic [NP-1:0]         hreadyout;
  logic [NP-1:0]         hresp;
  logic [NP-1:0][31:0]   hrdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [NP][DEPTH];
  tx_t         q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_dut
    nanorv32_ahb_code_sram #(
      .ADDR_WIDTH (AW),
      .WAIT_STATES(WS_TAB[g]),
      .BASE_ADDR  (BASE_TAB[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hsel     (hsel[g]),
      .haddr    (haddr[g]),
      .htrans   (htrans[g]),
      .hsize    (hsize[g]),
      .hwrite   (hwrite[g]),
      .hwdata   (hwdata[g]),
      .hready   (hready[g]),
      .hreadyout(hreadyout[g]),
      .hresp    (hresp[g]),
      .hrdata   (hrdata[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int p, input logic [31:0] a, input logic [2:0] sz);
    longint off;
    off = longint'(a) - longint'(BASE_TAB[p]);
    if (off < 0 || off >= 4 * DEPTH || sz > 3'd2) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  // Byte-addressed view of the memory: each written byte lands in its own lane.
  task automatic mdl_write(input int p, input tx_t t);
    int off;
    off = int'(t.addr - BASE_TAB[p]);
    for (int i = 0; i < (1 << t.sz); i++) begin
      int b;
      b = off + i;
      mdl[p][b / 4][8 * (b % 4) +: 8] = t.wd[8 * (b % 4) +: 8];
    end
  endtask

  function automatic void push(input int p, input bit wr, input int sz, input int off,
                               input logic [31:0] wd, input int gap = 0,
                               input bit cc = 0, input logic [31:0] cv = 0);
    tx_t t;
    t.wr = wr; t.sz = 3'(sz); t.addr = BASE_TAB[p] + 32'(off);
    t.wd = wd; t.gap = gap; t.cc = cc; t.cv = cv;
    q.push_back(t);
  endfunction

  task automatic drive_addr(input int p, input tx_t t);
    hsel[p]   = 1'b1;
    htrans[p] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    haddr[p]  = t.addr;
    hsize[p]  = t.sz;
    hwrite[p] = t.wr;
  endtask

  // Non-transfers: unselected NONSEQ, IDLE, BUSY, or (with no data phase
  // pending) a selected NONSEQ while another slave holds hready low.
  task automatic drive_idle(input int p, input bit may_stall);
    int k;
    k = may_stall ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
    haddr[p]  = BASE_TAB[p] + 32'($urandom_range(0, DEPTH - 1) << 2);
    hsize[p]  = 3'd2;
    hwrite[p] = 1'($urandom_range(0, 1));
    case (k)
      0:       begin hsel[p] = 1'b0; htrans[p] = 2'b10; end
      1:       begin hsel[p] = 1'b1; htrans[p] = 2'b00; end
      2:       begin hsel[p] = 1'b1; htrans[p] = 2'b01; end
      default: begin hsel[p] = 1'b1; htrans[p] = 2'b10; hready[p] = 1'b0; end
    endcase
  endtask

  // Plays the queue on port p, one cycle per iteration, checking all outputs
  // every cycle. Bus hready follows the model's expected hreadyout.
  task automatic run(input int p);
    tx_t         cur;
    bit          cur_v, busy, last, lg;
    int          dp;
    logic        exp_rdy, exp_rsp;
    logic [31:0] exp_dat;
    cur_v = 1'b0;
    dp    = 0;
    while (q.size() > 0 || cur_v) begin
      @(negedge clk);
      exp_rdy = 1'b1; exp_rsp = 1'b0; exp_dat = 32'h0; last = 1'b1;
      lg = cur_v && legal(p, cur.addr, cur.sz);
      if (cur_v && lg) begin
        last    = (dp == WS_TAB[p]);
        exp_rdy = last;
        if (last && !cur.wr) exp_dat = mdl[p][int'(cur.addr - BASE_TAB[p]) / 4];
      end else if (cur_v) begin
        last    = (dp == 1);
        exp_rdy = last;
        exp_rsp = 1'b1;
      end
      check($sformatf("p%0d_hreadyout", p), 32'(hreadyout[p]), 32'(exp_rdy));
      check($sformatf("p%0d_hresp", p), 32'(hresp[p]), 32'(exp_rsp));
      check($sformatf("p%0d_hrdata", p), hrdata[p], exp_dat);
      if (cur_v && lg && last && !cur.wr && cur.cc)
        check($sformatf("p%0d_rd_const@%h", p, cur.addr), hrdata[p], cur.cv);

      hwdata[p] = (cur_v && cur.wr) ? cur.wd : $urandom();
      hready[p] = exp_rdy;
      busy      = cur_v;
      if (last) begin
        if (cur_v && lg && cur.wr) mdl_write(p, cur);
        cur_v = 1'b0;
      end else begin
        dp++;
      end

      if (q.size() > 0 && q[0].gap == 0) begin
        drive_addr(p, q[0]);
        if (last) begin
          cur   = q.pop_front();
          cur_v = 1'b1;
          dp    = 0;
        end
      end else begin
        if (q.size() > 0) q[0].gap = q[0].gap - 1;
        drive_idle(p, !busy);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    hsel   = '0;
    haddr  = '0;
    htrans = '0;
    hsize  = '0;
    hwrite = '0;
    hwdata = '0;
    hready = '1;

    // Reset state.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("p%0d_rst_hreadyout", p), 32'(hreadyout[p]), 32'd1);
      check($sformatf("p%0d_rst_hresp", p), 32'(hresp[p]), 32'd0);
      check($sformatf("p%0d_rst_hrdata", p), hrdata[p], 32'd0);
    end

    for (int p = 0; p < NP; p++) begin
      // Fill every word so all later reads have a known value.
      for (int w = 0; w < DEPTH; w++) push(p, 1, 2, 4 * w, $urandom());
      run(p);

      // Word write then read.
      push(p, 1, 2, 'h10, 32'hDEADBEEF);
      push(p, 0, 2, 'h10, 0, 0, 1, 32'hDEADBEEF);
      // Byte and half-word lane merges.
      push(p, 1, 2, 'h10, 32'h11223344);
      push(p, 1, 0, 'h13, 32'hA5A5A5A5);
      push(p, 0, 2, 'h10, 0, 0, 1, 32'hA5223344);
      push(p, 1, 1, 'h12, 32'hBEEFBEEF);
      push(p, 0, 2, 'h10, 0, 0, 1, 32'hBEEF3344);
      // Illegal transfers: past the top, below the base, misaligned, oversize.
      push(p, 0, 2, 4 * DEPTH, 0);
      push(p, 1, 1, 'h11, 32'hFFFFFFFF);
      push(p, 1, 2, 'h12, 32'h0BAD0BAD, 1);
      push(p, 1, 3, 'h10, 32'h0BAD0BAD);
      push(p, 1, 2, -4, 32'h0BAD0BAD, 2);
      push(p, 0, 2, 'h10, 0, 0, 1, 32'hBEEF3344);
      // Back-to-back write/read of one word, then the same read after idles.
      push(p, 1, 2, 'h20, 32'h5A5A5A5A);
      push(p, 0, 2, 'h20, 0, 0, 1, 32'h5A5A5A5A);
      push(p, 0, 2, 'h20, 0, 3, 1, 32'h5A5A5A5A);
      run(p);

      // Random mix: mostly legal, some out of range / misaligned / oversize.
      for (int n = 0; n < 150; n++) begin
        int sz, off;
        sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) off = 4 * DEPTH + 4 * int'($urandom_range(0, 7));
        else begin
          off = int'($urandom_range(0, 4 * DEPTH - 1));
          if (sz < 3 && $urandom_range(0, 7) != 0) off = off - (off % (1 << sz));
        end
        push(p, 1'($urandom_range(0, 1)), sz, off, $urandom(), int'($urandom_range(0, 2)));
      end
      run(p);
    end

    // Reset in the middle of a 3-wait-state write data phase.
    @(negedge clk);
    hready[2] = 1'b1;
    hwdata[2] = 32'hCAFEF00D;
    begin
      tx_t t;
      t.wr = 1'b1; t.sz = 3'd2; t.addr = BASE_TAB[2] + 32'h30;
      t.wd = 32'hCAFEF00D; t.gap = 0; t.cc = 1'b0; t.cv = 32'h0;
      drive_addr(2, t);
    end
    @(negedge clk);
    hsel[2]   = 1'b0;
    hready[2] = 1'b0;
    check("rst_mid_wait0", 32'(hreadyout[2]), 32'd0);
    @(negedge clk);
    check("rst_mid_wait1", 32'(hreadyout[2]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hreadyout", 32'(hreadyout[2]), 32'd1);
    check("rst_mid_hresp", 32'(hresp[2]), 32'd0);
    check("rst_mid_hrdata", hrdata[2], 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    hready[2] = 1'b1;
    push(2, 0, 2, 'h30, 0, 1, 1, mdl[2]['h30 / 4]);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
